dmem_resp: RTL and testbench

Data-memory responder for the 5-stage core: the target end of the load/store interface driven by the MEM stage. It accepts one request at a time over a valid/ready handshake and performs RV32I byte, halfword and word loads and stores against an internal word-organised array. It then returns a registered response over a second valid/ready handshake after a programmable number of wait cycles. It sits beside `inst_mem`, attached to the MEM stage port.

---
 rtl/dmem_resp_pkg.sv | 32 +++
 rtl/dmem_lane.sv | 53 +++++
 rtl/dmem_resp.sv | 171 +++++++++++++++++
 tb/tb_dmem_resp.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the data-memory responder: width codes, FSM states,
// request payload and the funct3 legality helper.
package dmem_resp_pkg;

    localparam int unsigned DMEM_WAIT_WIDTH = 4;
    localparam int unsigned XLEN            = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [2:0]      funct3;
    } dmem_req_t;

    // Unsigned-load codes have no store counterpart.
    function automatic logic funct3_illegal(input logic [2:0] f3, input logic we);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (f3[2] && we);
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering for RV32I loads/stores: write enables, replicated store
// data, extended load data and misalignment detection.
module dmem_lane
    import dmem_resp_pkg::*;
(
    input  logic [1:0]      i_off,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rword,
    output logic [3:0]      o_be_c,
    output logic [XLEN-1:0] o_wdata_c,
    output logic [XLEN-1:0] o_rdata_c,
    output logic            o_misalign_c
);

    logic [1:0]      w_off;
    logic [XLEN-1:0] w_rshift;

    // Low address bits are masked to the access width; misalignment is only flagged.
    always_comb begin
        w_off        = i_off;
        o_be_c       = 4'b0000;
        o_wdata_c    = i_wdata;
        o_misalign_c = 1'b0;
        case (i_funct3[1:0])
            2'b00: begin
                o_be_c    = 4'(4'b0001 << i_off);
                o_wdata_c = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_misalign_c = i_off[0];
                w_off        = {i_off[1], 1'b0};
                o_be_c       = 4'(4'b0011 << w_off);
                o_wdata_c    = {2{i_wdata[15:0]}};
            end
            default: begin
                o_misalign_c = |i_off;
                w_off        = 2'b00;
                o_be_c       = 4'b1111;
            end
        endcase

        w_rshift = i_rword >> {w_off, 3'b000};
        case (i_funct3[1:0])
            2'b00:   o_rdata_c = i_funct3[2] ? {24'b0, w_rshift[7:0]}
                                             : {{24{w_rshift[7]}}, w_rshift[7:0]};
            2'b01:   o_rdata_c = i_funct3[2] ? {16'b0, w_rshift[15:0]}
                                             : {{16{w_rshift[15]}}, w_rshift[15:0]};
            default: o_rdata_c = w_rshift;
        endcase
    end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder for the MEM stage: one request at a time, programmable
// wait, registered response. Define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses.
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [2:0]      req_funct3,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err
);

    localparam int unsigned IDX_W = ADDR_WIDTH - 2;
    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam logic [DMEM_WAIT_WIDTH-1:0] WAIT_INIT =
        (WAIT_CYCLES > 0) ? DMEM_WAIT_WIDTH'(WAIT_CYCLES - 1) : '0;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam logic MISALIGN_TRAP = 1'b1;
`else
    localparam logic MISALIGN_TRAP = 1'b0;
`endif

    state_e                     r_state;
    state_e                     w_state_next;
    logic [DMEM_WAIT_WIDTH-1:0] r_cnt;
    logic [DMEM_WAIT_WIDTH-1:0] w_cnt_next;
    dmem_req_t                  r_req;
    dmem_req_t                  w_req_in;
    dmem_req_t                  w_src;
    logic                       w_accept;
    logic                       w_access;

    logic                       r_req_ready;
    logic                       r_resp_valid;
    logic                       r_resp_err;
    logic [XLEN-1:0]            r_resp_rdata;

    logic [XLEN-1:0]            r_mem [DEPTH];
    logic [IDX_W-1:0]           w_idx;
    logic [XLEN-1:0]            w_rword;
    logic [3:0]                 w_be;
    logic [XLEN-1:0]            w_wdata_lane;
    logic [XLEN-1:0]            w_rdata_lane;
    logic                       w_misalign;
    logic                       w_oob;
    logic                       w_illegal;
    logic                       w_fault;
    logic                       w_mem_we;

    assign w_req_in = {req_we, req_addr, req_wdata, req_funct3};

    // With zero wait the access happens on the accepting edge, before the latch holds the request.
    assign w_src   = (r_state == ST_IDLE) ? w_req_in : r_req;
    assign w_idx   = w_src.addr[ADDR_WIDTH-1:2];
    assign w_rword = r_mem[w_idx];

    dmem_lane u_lane (
        .i_off        (w_src.addr[1:0]),
        .i_funct3     (w_src.funct3),
        .i_wdata      (w_src.wdata),
        .i_rword      (w_rword),
        .o_be_c       (w_be),
        .o_wdata_c    (w_wdata_lane),
        .o_rdata_c    (w_rdata_lane),
        .o_misalign_c (w_misalign)
    );

    assign w_oob     = |(w_src.addr >> ADDR_WIDTH);
    assign w_illegal = funct3_illegal(w_src.funct3, w_src.we);
    assign w_fault   = w_oob | w_illegal | (MISALIGN_TRAP & w_misalign);
    assign w_mem_we  = rst & w_access & w_src.we & ~w_fault;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, wait counter and access strobe.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_access     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_state_next = ST_RESP;
                        w_access     = 1'b1;
                    end else begin
                        w_state_next = ST_WAIT;
                        w_cnt_next   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_RESP;
                    w_access     = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Request latch, counter and registered response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_req        <= '0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_req_ready <= (w_state_next == ST_IDLE);
            if (w_accept) begin
                r_req <= w_req_in;
            end
            if (w_access) begin
                r_resp_valid <= 1'b1;
                r_resp_err   <= w_fault;
                r_resp_rdata <= (w_fault || w_src.we) ? '0 : w_rdata_lane;
            end else if ((r_state == ST_RESP) && resp_ready) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata_lane[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: directed load/store cases, faults, stall,
// mid-operation reset, then a randomised region checked against a byte model.
module tb_dmem_resp;

    localparam int unsigned TB_AW   = 12;
    localparam int unsigned TB_WAIT = 1;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_checks;
    int n_fail;

    logic [32:0] sb_q [$];
    logic [7:0]  m_bytes [0:4095];

    dmem_resp #(.ADDR_WIDTH(TB_AW), .WAIT_CYCLES(TB_WAIT)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; expected response is queued at drive time, popped at response time.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, input logic [31:0] exp_rd, input logic exp_err,
                          input int stall);
        logic [32:0] exp;
        int n;
        int lat;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        if (!req_ready) begin
            check_eq("accept_timeout", 32'(req_ready), 32'd1);
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        sb_q.push_back({exp_err, exp_rd});
        tick();
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_funct3 = 3'($urandom);
        check_eq("busy_ready", 32'(req_ready), 32'd0);
        lat = 1;
        while (!resp_valid && lat < 40) begin
            tick();
            lat++;
        end
        exp = sb_q.pop_front();
        if (!resp_valid) begin
            check_eq("resp_timeout", 32'(resp_valid), 32'd1);
            return;
        end
        check_eq("latency", 32'(lat), 32'(TB_WAIT + 1));
        check_eq("rdata", resp_rdata, exp[31:0]);
        check_eq("err", 32'(resp_err), 32'(exp[32]));
        for (int i = 0; i < stall; i++) begin
            tick();
            check_eq("stall_valid", 32'(resp_valid), 32'd1);
            check_eq("stall_rdata", resp_rdata, exp[31:0]);
            check_eq("stall_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check_eq("post_valid", 32'(resp_valid), 32'd0);
        check_eq("post_ready", 32'(req_ready), 32'd1);
    endtask

    function automatic logic [31:0] model_load(input logic [11:0] a, input logic [2:0] f3);
        logic [11:0] b;
        b = a & 12'hFFC;
        case (f3)
            3'b000:  return {{24{m_bytes[a][7]}}, m_bytes[a]};
            3'b100:  return {24'b0, m_bytes[a]};
            3'b001:  return {{16{m_bytes[a+1][7]}}, m_bytes[a+1], m_bytes[a]};
            3'b101:  return {16'b0, m_bytes[a+1], m_bytes[a]};
            default: return {m_bytes[b+3], m_bytes[b+2], m_bytes[b+1], m_bytes[b]};
        endcase
    endfunction

    task automatic model_store(input logic [11:0] a, input logic [31:0] d, input logic [2:0] f3);
        case (f3)
            3'b000: m_bytes[a] = d[7:0];
            3'b001: begin
                m_bytes[a]   = d[7:0];
                m_bytes[a+1] = d[15:8];
            end
            default: begin
                m_bytes[a]   = d[7:0];
                m_bytes[a+1] = d[15:8];
                m_bytes[a+2] = d[23:16];
                m_bytes[a+3] = d[31:24];
            end
        endcase
    endtask

    initial begin
        logic [2:0]  ld_codes [5];
        logic [2:0]  f3;
        logic [11:0] a;
        logic [31:0] d;
        logic        we;
        n_checks   = 0;
        n_fail     = 0;
        ld_codes   = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_funct3 = '0;
        resp_ready = 1'b0;

        repeat (3) tick();
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_rdata", resp_rdata, 32'd0);
        check_eq("rst_err", 32'(resp_err), 32'd0);
        rst = 1'b1;
        tick();
        check_eq("rst_exit_ready", 32'(req_ready), 32'd1);

        // Basic word store/load and lane extraction
        do_req(1'b1, 32'h010, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0, 0);
        do_req(1'b0, 32'h010, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0, 0);
        do_req(1'b0, 32'h013, 32'h0,        3'b000, 32'hFFFFFFDE, 1'b0, 0);
        do_req(1'b0, 32'h013, 32'h0,        3'b100, 32'h000000DE, 1'b0, 0);
        do_req(1'b0, 32'h012, 32'h0,        3'b001, 32'hFFFFDEAD, 1'b0, 0);
        do_req(1'b0, 32'h010, 32'h0,        3'b101, 32'h0000BEEF, 1'b0, 0);
        do_req(1'b1, 32'h011, 32'hFFFFFF12, 3'b000, 32'h0, 1'b0, 0);
        do_req(1'b0, 32'h010, 32'h0,        3'b010, 32'hDEAD12EF, 1'b0, 0);

        // Faults: out of range, illegal codes, unsigned store
        do_req(1'b1, 32'h000, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0, 0);
        do_req(1'b0, 32'h1000, 32'h0,       3'b010, 32'h0, 1'b1, 0);
        do_req(1'b1, 32'h1000, 32'h12345678, 3'b010, 32'h0, 1'b1, 0);
        do_req(1'b0, 32'h000, 32'h0,        3'b010, 32'hCAFEF00D, 1'b0, 0);
        do_req(1'b0, 32'h010, 32'h0,        3'b011, 32'h0, 1'b1, 0);
        do_req(1'b0, 32'h010, 32'h0,        3'b110, 32'h0, 1'b1, 0);
        do_req(1'b1, 32'h010, 32'h000000AA, 3'b100, 32'h0, 1'b1, 0);
        do_req(1'b0, 32'h010, 32'h0,        3'b010, 32'hDEAD12EF, 1'b0, 5);

        // Halfword store into upper lanes, then misaligned word load
        do_req(1'b1, 32'h012, 32'hABCD1234, 3'b001, 32'h0, 1'b0, 0);
        do_req(1'b0, 32'h010, 32'h0,        3'b010, 32'h123412EF, 1'b0, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        do_req(1'b0, 32'h012, 32'h0,        3'b010, 32'h0, 1'b1, 0);
`else
        do_req(1'b0, 32'h012, 32'h0,        3'b010, 32'h123412EF, 1'b0, 0);
`endif

        // Reset while a store waits: store is dropped, no response appears
        do_req(1'b1, 32'h020, 32'h11111111, 3'b010, 32'h0, 1'b0, 0);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h020;
        req_wdata  = 32'h00000055;
        req_funct3 = 3'b010;
        tick();
        req_valid = 1'b0;
        rst       = 1'b0;
        tick();
        check_eq("midrst_valid", 32'(resp_valid), 32'd0);
        check_eq("midrst_ready", 32'(req_ready), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("midrst_no_resp", 32'(resp_valid), 32'd0);
        end
        do_req(1'b0, 32'h020, 32'h0, 3'b010, 32'h11111111, 1'b0, 0);

        // Randomised accesses in a pre-initialised region against the byte model
        for (int i = 0; i < 16; i++) begin
            a = 12'(12'h100 + 4 * i);
            d = $urandom;
            model_store(a, d, 3'b010);
            do_req(1'b1, 32'(a), d, 3'b010, 32'h0, 1'b0, 0);
        end
        for (int i = 0; i < 30; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = we ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 4)];
            a  = 12'(12'h100 + $urandom_range(0, 63));
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            d = $urandom;
            if (we) begin
                model_store(a, d, f3);
                do_req(1'b1, 32'(a), d, f3, 32'h0, 1'b0, i % 3);
            end else begin
                do_req(1'b0, 32'(a), 32'h0, f3, model_load(a, f3), 1'b0, i % 3);
            end
        end

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
